// File: rtl/regfile_write_sequencer_pkg.sv
// Shared definitions for the register-file write sequencer: register
// indices, default widths and the write-back FSM state encoding.
package aardvark_pkg;

    localparam int REG_S0 = 0;
    localparam int REG_S1 = 1;
    localparam int REG_SP = 2;
    localparam int REG_RA = 3;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        RELEASE = 2'd3
    } wb_state_t;

endpackage

// File: rtl/regfile_write_sequencer_if.sv
// Result-write handshake between the execute/memory stage (master) and
// the write sequencer (slave).
interface regfile_write_sequencer_if #(
    parameter int DATA_W = aardvark_pkg::DATA_W,
    parameter int ADDR_W = aardvark_pkg::ADDR_W
);
    logic              res_valid;
    logic              res_ready;
    logic              res_link;
    logic [ADDR_W-1:0] res_addr;
    logic [DATA_W-1:0] res_data;

    modport master (
        output res_valid, res_link, res_addr, res_data,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_link, res_addr, res_data,
        output res_ready
    );
endinterface

// File: rtl/regfile_write_sequencer_wb_fifo.sv
// Small result queue for the write sequencer. Exposes its entries in age
// order (index 0 = oldest) so the top can build the pending scoreboard and,
// when WB_BYPASS_EN is defined, the forwarding lookup.
// Ready is registered: it reflects "not full" after the current edge, so a
// pop while full re-opens the queue only on the following cycle.
module wb_fifo #(
    parameter int DATA_W = aardvark_pkg::DATA_W,
    parameter int ADDR_W = aardvark_pkg::ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [ADDR_W-1:0]             push_addr,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [ADDR_W-1:0]             head_addr,
    output logic [DATA_W-1:0]             head_data,
    output logic                          empty,
    output logic                          ready,
    output logic [DEPTH-1:0]              entry_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr
`ifdef WB_BYPASS_EN
    , output logic [DEPTH-1:0][DATA_W-1:0] entry_data
`endif
);
    import aardvark_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] mem_addr_r;
    logic [DEPTH-1:0][DATA_W-1:0] mem_data_r;
    logic [PTR_W-1:0]             wr_ptr_r;
    logic [PTR_W-1:0]             rd_ptr_r;
    logic [CNT_W-1:0]             count_r;
    logic [CNT_W-1:0]             count_next_s;
    logic                         ready_r;
    logic                         push_ok_s;
    logic                         pop_ok_s;

    assign empty     = (count_r == {CNT_W{1'b0}});
    assign ready     = ready_r;
    assign push_ok_s = push & ready_r;
    assign pop_ok_s  = pop & ~empty;
    assign head_addr = mem_addr_r[rd_ptr_r];
    assign head_data = mem_data_r[rd_ptr_r];

    // Occupancy after this edge, used for both the counter and registered ready.
    always_comb begin
        count_next_s = count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
    end

    // Queue storage, wrapping pointers, occupancy and registered ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_r <= '0;
            mem_data_r <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            ready_r    <= 1'b1;
        end else begin
            if (push_ok_s) begin
                mem_addr_r[wr_ptr_r] <= push_addr;
                mem_data_r[wr_ptr_r] <= push_data;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s != CNT_W'(DEPTH));
        end
    end

    // Present the live entries oldest-first for the scoreboard and bypass.
    always_comb begin
        entry_valid = '0;
        entry_addr  = '0;
`ifdef WB_BYPASS_EN
        entry_data  = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = (CNT_W'(i) < count_r);
            entry_addr[i]  = mem_addr_r[rd_ptr_r + PTR_W'(i)];
`ifdef WB_BYPASS_EN
            entry_data[i]  = mem_data_r[rd_ptr_r + PTR_W'(i)];
`endif
        end
    end
endmodule

// File: rtl/regfile_write_sequencer.sv
// Write-side front end for the 4-entry register file. Queues result writes
// and replays each one as SETUP (address/data presented), STROBE
// (regWrite high) and RELEASE (regWrite low, address/data held).
// Optional feature macro: WB_BYPASS_EN adds the byp_addr/byp_hit/byp_data
// forwarding lookup over pending writes.
module regfile_write_sequencer #(
    parameter int DATA_W = aardvark_pkg::DATA_W,
    parameter int ADDR_W = aardvark_pkg::ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    regfile_write_sequencer_if.slave    res,
    output logic                        regWrite,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [DATA_W-1:0]           dataToWrite,
    output logic [3:0]                  pending,
    output logic                        busy
`ifdef WB_BYPASS_EN
    , input  logic [ADDR_W-1:0]         byp_addr
    , output logic                      byp_hit
    , output logic [DATA_W-1:0]         byp_data
`endif
);
    import aardvark_pkg::*;

    wb_state_t                    state_r;
    logic                         reg_write_r;
    logic [ADDR_W-1:0]            wr_addr_r;
    logic [DATA_W-1:0]            wr_data_r;
    logic [ADDR_W-1:0]            push_addr_s;
    logic                         pop_s;
    logic [ADDR_W-1:0]            head_addr_s;
    logic [DATA_W-1:0]            head_data_s;
    logic                         fifo_empty_s;
    logic [DEPTH-1:0]             entry_valid_s;
    logic [DEPTH-1:0][ADDR_W-1:0] entry_addr_s;
    logic [3:0]                   pending_s;
    logic                         in_flight_s;
`ifdef WB_BYPASS_EN
    logic [DEPTH-1:0][DATA_W-1:0] entry_data_s;
    logic                         byp_hit_s;
    logic [DATA_W-1:0]            byp_data_s;
`endif

    // jal link writes always land in $ra regardless of res_addr.
    always_comb begin
        if (res.res_link) begin
            push_addr_s = ADDR_W'(REG_RA);
        end else begin
            push_addr_s = res.res_addr;
        end
    end

    assign in_flight_s = (state_r != IDLE);
    assign pop_s       = ~fifo_empty_s & ((state_r == IDLE) | (state_r == RELEASE));

    wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (res.res_valid),
        .push_addr   (push_addr_s),
        .push_data   (res.res_data),
        .pop         (pop_s),
        .head_addr   (head_addr_s),
        .head_data   (head_data_s),
        .empty       (fifo_empty_s),
        .ready       (res.res_ready),
        .entry_valid (entry_valid_s),
        .entry_addr  (entry_addr_s)
`ifdef WB_BYPASS_EN
        , .entry_data (entry_data_s)
`endif
    );

    // Setup/strobe/release sequencer; address and data load only on entry to SETUP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            reg_write_r <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= '0;
        end else begin
            case (state_r)
                IDLE, RELEASE: begin
                    reg_write_r <= 1'b0;
                    if (pop_s) begin
                        wr_addr_r <= head_addr_s;
                        wr_data_r <= head_data_s;
                        state_r   <= SETUP;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                SETUP: begin
                    reg_write_r <= 1'b1;
                    state_r     <= STROBE;
                end
                STROBE: begin
                    reg_write_r <= 1'b0;
                    state_r     <= RELEASE;
                end
                default: begin
                    reg_write_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // Scoreboard of registers with a queued or in-flight write.
    always_comb begin
        pending_s = 4'b0000;
        if (in_flight_s) begin
            pending_s[wr_addr_r] = 1'b1;
        end else begin
            pending_s = 4'b0000;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid_s[i]) begin
                pending_s[entry_addr_s[i]] = 1'b1;
            end else begin
                pending_s = pending_s;
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Youngest matching write wins: in-flight first, then queue oldest to newest.
    always_comb begin
        byp_hit_s  = 1'b0;
        byp_data_s = '0;
        if (in_flight_s && (wr_addr_r == byp_addr)) begin
            byp_hit_s  = 1'b1;
            byp_data_s = wr_data_r;
        end else begin
            byp_hit_s  = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid_s[i] && (entry_addr_s[i] == byp_addr)) begin
                byp_hit_s  = 1'b1;
                byp_data_s = entry_data_s[i];
            end else begin
                byp_hit_s  = byp_hit_s;
            end
        end
    end

    assign byp_hit  = byp_hit_s;
    assign byp_data = byp_data_s;
`endif

    assign regWrite    = reg_write_r;
    assign wr_addr     = wr_addr_r;
    assign dataToWrite = wr_data_r;
    assign pending     = pending_s;
    assign busy        = in_flight_s | ~fifo_empty_s;
endmodule
